// File: rtl/frame_buf_multi.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_multi
// Description : Multi-buffer frame store. Holds NUM_BUFS frames of FRAME_LEN
//               words in one internal array. The write side fills buffers in
//               rotation under valid/ready; the read side drains committed
//               frames in FIFO order with full backpressure. Single clock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wr_clk        sole clock, both sides
//   reset         synchronous, active-high; discards every frame
//   wr_valid      write word offered
//   wr_ready      a write word can be accepted (a free buffer exists)
//   wr_data       write word
//   wr_abort      discard the partially written frame (wins over a transfer)
//   rd_ready      consumer accepts rd_data
//   rd_valid      rd_data holds a valid word
//   rd_data       read word
//   rd_last       rd_data is the final word of its frame
//   rd_buf        buffer index rd_data came from
//   frames_avail  committed frames not yet fully issued to the read port
// ============================================================================
module frame_buf_multi #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3,
   parameter int FRAME_LEN  = 1 << ADDR_WIDTH,
   parameter int BUF_W      = 1,
   parameter int NUM_BUFS   = 1 << BUF_W
) (
   input  logic                  wr_clk,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_abort,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic [BUF_W-1:0]      rd_buf,
   output logic [BUF_W:0]        frames_avail
);

   // Storage is addressed as {buffer, word}, so it is sized for the full
   // in-buffer address space even when FRAME_LEN is shorter.
   localparam int                    c_depth     = NUM_BUFS * (1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FRAME_LEN - 1);
   localparam logic [BUF_W-1:0]      c_last_buf  = BUF_W'(NUM_BUFS - 1);
   localparam logic [BUF_W:0]        c_num_bufs  = (BUF_W + 1)'(NUM_BUFS);

   logic [DATA_WIDTH-1:0] r_mem [c_depth];

   // Write side state
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [BUF_W-1:0]      r_wr_buf;

   // Read side state
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [BUF_W-1:0]      r_rd_buf_ptr;

   // Committed frames not yet fully issued
   logic [BUF_W:0]        r_count;

   // Output register
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_last;
   logic [BUF_W-1:0]      r_rd_buf;

   logic w_wr_xfer;
   logic w_commit;
   logic w_issue;
   logic w_release;

   function automatic logic [BUF_W-1:0] next_buf(input logic [BUF_W-1:0] b);
      next_buf = (b == c_last_buf) ? '0 : b + 1'b1;
   endfunction

   // A free buffer exists whenever fewer than NUM_BUFS frames are committed;
   // the write buffer can then never alias a frame still waiting to be read.
   assign wr_ready  = !reset && (r_count < c_num_bufs);

   // Abort drops the word offered in the same cycle.
   assign w_wr_xfer = wr_valid && wr_ready && !wr_abort;
   assign w_commit  = w_wr_xfer && (r_wr_addr == c_last_addr);

   // Issue refills the output register when it is empty or being drained.
   assign w_issue   = (r_count != '0) && (!r_rd_valid || rd_ready);
   assign w_release = w_issue && (r_rd_addr == c_last_addr);

   // ---------------------------------------------------------------------
   // Frame storage (contents are deliberately not cleared by reset)
   // ---------------------------------------------------------------------
   always_ff @(posedge wr_clk) begin
      if (w_wr_xfer) begin
         r_mem[{r_wr_buf, r_wr_addr}] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------
   // Write pointer
   // ---------------------------------------------------------------------
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_wr_addr <= '0;
         r_wr_buf  <= '0;
      end else if (wr_abort) begin
         // Rewind to the start of the same buffer; the partial frame is lost.
         r_wr_addr <= '0;
      end else if (w_commit) begin
         r_wr_addr <= '0;
         r_wr_buf  <= next_buf(r_wr_buf);
      end else if (w_wr_xfer) begin
         r_wr_addr <= r_wr_addr + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Read pointer
   // ---------------------------------------------------------------------
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_rd_addr    <= '0;
         r_rd_buf_ptr <= '0;
      end else if (w_release) begin
         r_rd_addr    <= '0;
         r_rd_buf_ptr <= next_buf(r_rd_buf_ptr);
      end else if (w_issue) begin
         r_rd_addr    <= r_rd_addr + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Committed-frame count; a commit and a release together cancel out.
   // ---------------------------------------------------------------------
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         case ({w_commit, w_release})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output register. A released buffer's last word is captured here on the
   // release edge, so the writer may reuse that buffer immediately after.
   // ---------------------------------------------------------------------
   always_ff @(posedge wr_clk) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_last  <= 1'b0;
         r_rd_buf   <= '0;
      end else if (w_issue) begin
         r_rd_valid <= 1'b1;
         r_rd_data  <= r_mem[{r_rd_buf_ptr, r_rd_addr}];
         r_rd_last  <= (r_rd_addr == c_last_addr);
         r_rd_buf   <= r_rd_buf_ptr;
      end else if (r_rd_valid && rd_ready) begin
         r_rd_valid <= 1'b0;
      end
   end

   assign rd_valid     = r_rd_valid;
   assign rd_data      = r_rd_data;
   assign rd_last      = r_rd_last;
   assign rd_buf       = r_rd_buf;
   assign frames_avail = r_count;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_frame_buf_multi
// Description : Directed self-checking bench for frame_buf_multi
//               (default parameters: 8-word frames, 2 buffers).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_multi;

   logic        wr_clk   = 1'b0;
   logic        reset    = 1'b1;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data  = '0;
   logic        wr_abort = 1'b0;
   logic        rd_ready = 1'b1;
   logic        wr_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_last;
   logic [0:0]  rd_buf;
   logic [1:0]  frames_avail;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected read words: {buf, last, data}
   logic [33:0] exp_q[$];

   always #5 wr_clk = ~wr_clk;

   frame_buf_multi dut (
      .wr_clk       (wr_clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .wr_abort     (wr_abort),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_last      (rd_last),
      .rd_buf       (rd_buf),
      .frames_avail (frames_avail)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; return 1 ns after the edge (sample/drive point).
   task automatic cyc();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_abort = 1'b0;
      rd_ready = 1'b1;
      exp_q.delete();
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   // Word i of a burst carries base + frame*16 + index.
   task automatic write_words(input logic [31:0] base, input int n);
      int  i      = 0;
      int  budget = 0;
      bit  acc;
      while (i < n && budget < n * 40) begin
         wr_valid = 1'b1;
         wr_data  = base + 32'((i / 8) * 16 + (i % 8));
         acc      = wr_ready;
         cyc();
         if (acc) i++;
         budget++;
      end
      wr_valid = 1'b0;
      if (i != n) check("write_timeout", 64'(i), 64'(n));
   endtask

   task automatic push_frame(input logic [31:0] base, input logic [0:0] b);
      for (int i = 0; i < 8; i++) begin
         logic        l;
         logic [31:0] d;
         l = (i == 7);
         d = base + 32'(i);
         exp_q.push_back({b, l, d});
      end
   endtask

   // Consume words against exp_q. fa_first_last >= 0 additionally checks
   // frames_avail and wr_ready when the first frame-final word appears.
   task automatic drain(input int budget, input bit rnd, input int fa_first_last,
                        output int gaps, output int max_fa);
      bit started   = 1'b0;
      bit seen_last = 1'b0;
      gaps   = 0;
      max_fa = 0;
      for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
         rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (int'(frames_avail) > max_fa) max_fa = int'(frames_avail);
         if (rd_valid) begin
            check("rd_word", {30'b0, rd_buf, rd_last, rd_data}, {30'b0, exp_q[0]});
            started = 1'b1;
            if (rd_last && !seen_last && fa_first_last >= 0) begin
               seen_last = 1'b1;
               check("fa_after_release", 64'(frames_avail), 64'(fa_first_last));
               check("wr_ready_after_release", 64'(wr_ready), 64'(1));
            end
            if (rd_ready) void'(exp_q.pop_front());
         end else if (started) begin
            gaps++;
         end
         cyc();
      end
      check("drain_left", 64'(exp_q.size()), 64'(0));
      rd_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int gaps;
      int mx;

      // ---- 1: reset state, single frame round trip ----
      cyc();
      cyc();
      check("rst_wr_ready", 64'(wr_ready), 64'(0));
      check("rst_rd_valid", 64'(rd_valid), 64'(0));
      check("rst_rd_last",  64'(rd_last),  64'(0));
      check("rst_rd_buf",   64'(rd_buf),   64'(0));
      check("rst_rd_data",  64'(rd_data),  64'(0));
      check("rst_fa",       64'(frames_avail), 64'(0));
      reset = 1'b0;
      cyc();
      check("post_rst_wr_ready", 64'(wr_ready), 64'(1));
      write_words(32'h10, 8);
      check("t1_fa_after_commit", 64'(frames_avail), 64'(1));
      check("t1_rd_valid_latency", 64'(rd_valid), 64'(0));
      push_frame(32'h10, 1'b0);
      drain(40, 1'b0, 0, gaps, mx);
      check("t1_gaps", 64'(gaps), 64'(0));
      check("t1_fa_end", 64'(frames_avail), 64'(0));

      // ---- 2: fill both buffers under backpressure ----
      do_reset();
      rd_ready = 1'b0;
      write_words(32'h20, 16);
      check("t2_fa_full", 64'(frames_avail), 64'(2));
      check("t2_wr_ready_full", 64'(wr_ready), 64'(0));
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'h40 + 32'(i);
         check("t2_wr_ready_ignored", 64'(wr_ready), 64'(0));
         cyc();
      end
      wr_valid = 1'b0;
      check("t2_fa_still2", 64'(frames_avail), 64'(2));
      push_frame(32'h20, 1'b0);
      push_frame(32'h30, 1'b1);
      drain(60, 1'b0, 1, gaps, mx);
      cyc();
      cyc();
      check("t2_no_third", 64'(rd_valid), 64'(0));
      check("t2_fa_end", 64'(frames_avail), 64'(0));

      // ---- 3: continuous write and read, 5 frames ----
      do_reset();
      for (int f = 0; f < 5; f++) push_frame(32'(f * 16), 1'(f % 2));
      fork
         write_words(32'h0, 40);
         drain(200, 1'b0, -1, gaps, mx);
      join
      check("t3_gaps", 64'(gaps), 64'(0));
      check("t3_fa_max_le2", 64'(mx <= 2), 64'(1));

      // ---- 4: random rd_ready stalls, 4 frames ----
      do_reset();
      for (int f = 0; f < 4; f++) push_frame(32'h50 + 32'(f * 16), 1'(f % 2));
      fork
         write_words(32'h50, 32);
         drain(600, 1'b1, -1, gaps, mx);
      join
      check("t4_fa_end", 64'(frames_avail), 64'(0));

      // ---- 5: abort a partial frame ----
      do_reset();
      write_words(32'h90, 5);
      wr_valid = 1'b1;
      wr_data  = 32'h99;
      wr_abort = 1'b1;
      cyc();
      wr_abort = 1'b0;
      wr_valid = 1'b0;
      check("t5_fa_after_abort", 64'(frames_avail), 64'(0));
      check("t5_rd_valid_after_abort", 64'(rd_valid), 64'(0));
      write_words(32'hA0, 8);
      check("t5_fa_one", 64'(frames_avail), 64'(1));
      push_frame(32'hA0, 1'b0);
      drain(60, 1'b0, 0, gaps, mx);
      cyc();
      cyc();
      cyc();
      check("t5_no_extra", 64'(rd_valid), 64'(0));
      check("t5_fa_end", 64'(frames_avail), 64'(0));

      // ---- 6: reset in the middle of a read ----
      do_reset();
      rd_ready = 1'b0;
      write_words(32'hB0, 16);
      check("t6_fa_two", 64'(frames_avail), 64'(2));
      rd_ready = 1'b1;
      cyc();
      cyc();
      check("t6_fa_midread", 64'(frames_avail), 64'(2));
      check("t6_rd_valid_midread", 64'(rd_valid), 64'(1));
      reset = 1'b1;
      cyc();
      check("t6_rst_rd_valid", 64'(rd_valid), 64'(0));
      check("t6_rst_fa", 64'(frames_avail), 64'(0));
      reset = 1'b0;
      cyc();
      write_words(32'hD0, 8);
      push_frame(32'hD0, 1'b0);
      drain(40, 1'b0, 0, gaps, mx);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/frame_buf_multi.md
# frame_buf_multi

Parametrised multi-buffer frame store, successor to the single-buffer frame buffer. Holds NUM_BUFS complete frames of FRAME_LEN words in one internal array. The writer fills buffers in rotation under a valid/ready handshake. The reader drains only committed frames in FIFO order with full backpressure. Sits between the pixel/sample producer and the display/output engine. The whole block is single-clock, so there is no CDC inside.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 3, in-buffer address width
- FRAME_LEN, 1 << ADDR_WIDTH, words per frame; 2..(1 << ADDR_WIDTH)
- BUF_W, 1, buffer-index width
- NUM_BUFS, 1 << BUF_W, buffer count; power of two, ≥2
- wr_clk  in  1  sole clock; both sides run on it
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write word offered
- wr_ready  out  1  block can accept a write word
- wr_data  in  DATA_WIDTH  write word
- wr_abort  in  1  discard the partially written frame
- rd_ready  in  1  consumer accepts rd_data
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read word
- rd_last  out  1  rd_data is the final word of its frame
- rd_buf  out  BUF_W  index of the buffer rd_data came from
- frames_avail  out  BUF_W+1  committed frames not yet fully issued to the read port

## Operation
- Write transfer: wr_valid && wr_ready on a wr_clk edge. The word is stored at (wr_buf, wr_addr), then wr_addr increments.
- Transfer with wr_addr == FRAME_LEN-1 is a commit:
  - wr_addr → 0
  - wr_buf → wr_buf+1, mod NUM_BUFS
  - count +1
- wr_ready = !reset && (count < NUM_BUFS). It is combinational from the registered count.
- wr_abort (takes priority over a same-cycle transfer): wr_addr → 0 and wr_buf is unchanged, so the partial frame is discarded. No commit occurs; the word offered that cycle is dropped.
- Read issue condition: count > 0 && (!rd_valid || rd_ready).
  - On issue, the RAM is read at (rd_buf_ptr, rd_addr) into the output register; rd_addr increments.
  - Issue at rd_addr == FRAME_LEN-1 is a release: rd_addr → 0, rd_buf_ptr +1 mod NUM_BUFS, count −1.
- Output register:
  - Load on issue.
  - Clear rd_valid when rd_valid && rd_ready and there is no issue in the same cycle.
  - Hold all outputs while rd_valid && !rd_ready.
- rd_last and rd_buf are registered alongside rd_data.
- Commit and release in the same cycle leave count unchanged.
- Overwrite safety: a released buffer's last word is already in the output register. wr_buf never equals an unreleased, non-written buffer because count < NUM_BUFS is required to write.
- frames_avail = count.

## Timing
- Reset values:
  - wr_ready=0 during reset, 1 the cycle after
  - rd_valid=0, rd_last=0, rd_buf=0, rd_data=0, frames_avail=0
  - Internal wr_addr=0, wr_buf=0, rd_addr=0, rd_buf_ptr=0
- RAM contents are not cleared.
- Reset mid-frame discards all frames, both partial and committed.
- Throughput: 1 word/cycle on each side, sustained and concurrent.
- Commit at edge E0 → frames_avail=1 after E0; first issue at E1; rd_valid=1 after E1. Minimum write-commit to rd_valid latency is 2 edges.
- Release at edge E → count decrements after E → wr_ready can rise the cycle after E.
- Full (count == NUM_BUFS): wr_ready=0; wr_data is ignored.
- Empty (count == 0): no issue. rd_valid falls after the last word is taken.
- Wrap: the buffer index wraps NUM_BUFS-1 → 0 on both sides. Buffer order is strictly FIFO.
- A partial frame is never readable.

## Test plan
- Reset, then write 8 words 0x10..0x17 with rd_ready=1 (defaults) → frames_avail=1 one cycle after the last write. Read returns 0x10..0x17 back-to-back with rd_buf=0 and rd_last only on 0x17. frames_avail=0 after the last issue.
- Write 2 frames with rd_ready=0 → frames_avail=2 and wr_ready=0. A third frame's words are ignored. Assert rd_ready → frame 0 (rd_buf=0) then frame 1 (rd_buf=1). wr_ready=1 the cycle after frame 0's last issue.
- Continuous write and continuous read across 5 frames, with data = frame*16+index → no gaps after the first, rd_buf sequence 0,1,0,1,0, all data matches, frames_avail never exceeds 2.
- Random rd_ready toggling (including deassert while rd_valid) → rd_data/rd_last/rd_buf held stable while stalled. No word lost or duplicated across 4 frames.
- Write 5 words, pulse wr_abort, then write 8 words 0xA0..0xA7 → exactly one frame committed, in buffer 0, reading 0xA0..0xA7.
- Assert reset mid-read with frames_avail=2 → next cycle rd_valid=0, frames_avail=0. The next frame written lands in buffer 0 and reads back correctly.
